uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_arb_pkg.sv | 17 +
 rtl/uart_tx_baud.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 113 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared constants for the two-requester UART transmitter: state codes, default divider, frame sizes.
// The optional parity bit is enabled by defining UART_TX_PARITY_EN.
package uart_arb_pkg;

   localparam int DEFAULT_CLK_DIV   = 434;
   localparam int FRAME_BITS_BASE   = 10;
   localparam int FRAME_BITS_PARITY = 11;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_START  = 3'd1;
   localparam state_t ST_DATA   = 3'd2;
   localparam state_t ST_PARITY = 3'd3;
   localparam state_t ST_STOP   = 3'd4;

endpackage

// File: rtl/uart_tx_baud.sv
// Bit-period down-counter: reload sets CLK_DIV-1, bit_done marks the final cycle of a bit.
module uart_tx_baud
   import uart_arb_pkg::*;
#(
   parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
   input  logic sys_clk,
   input  logic RSTn,
   input  logic reload,
   output logic bit_done
);

   localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] RELOAD_VAL = CW'(CLK_DIV - 1);

   logic [CW-1:0] count_reg;

   always_ff @(posedge sys_clk) begin
      if (!RSTn) begin
         count_reg <= '0;
      end else if (reload) begin
         count_reg <= RELOAD_VAL;
      end else if (count_reg != '0) begin
         count_reg <= count_reg - CW'(1);
      end
   end

   // Parked at zero while idle; the FSM only acts on this outside IDLE.
   assign bit_done = (count_reg == '0);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter for two byte requesters feeding one 8N1 UART transmitter.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
   input  logic       sys_clk,
   input  logic       RSTn,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   output logic       req1_ready,
   output logic       tx,
   output logic       busy,
   output logic       grant
);

   state_t     state_reg;
   state_t     state_next;
   logic [7:0] data_reg;
   logic [2:0] bit_idx_reg;
   logic       grant_reg;
   logic       prio_reg;

   logic       idle;
   logic       win0;
   logic       win1;
   logic       accept;
   logic       bit_done;
   logic       reload;

   assign idle = (state_reg == ST_IDLE);

   // prio_reg names the requester that wins a tie; it always points away from the last grant.
   assign win0 = req0_valid && (!req1_valid || !prio_reg);
   assign win1 = req1_valid && (!req0_valid ||  prio_reg);

   assign req0_ready = idle && RSTn && win0;
   assign req1_ready = idle && RSTn && win1;
   assign accept     = req0_ready || req1_ready;

   assign reload = accept || (!idle && bit_done);

   uart_tx_baud #(
      .CLK_DIV (CLK_DIV)
   ) u_baud (
      .sys_clk  (sys_clk),
      .RSTn     (RSTn),
      .reload   (reload),
      .bit_done (bit_done)
   );

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:  if (accept)   state_next = ST_START;
         ST_START: if (bit_done) state_next = ST_DATA;
         ST_DATA: begin
            if (bit_done && bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
               state_next = ST_PARITY;
`else
               state_next = ST_STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: if (bit_done) state_next = ST_STOP;
`endif
         ST_STOP:  if (bit_done) state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!RSTn) begin
         state_reg   <= ST_IDLE;
         data_reg    <= '0;
         bit_idx_reg <= '0;
         grant_reg   <= 1'b0;
         prio_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            data_reg    <= req1_ready ? req1_data : req0_data;
            grant_reg   <= req1_ready;
            prio_reg    <= !req1_ready;
            bit_idx_reg <= '0;
         end else if (state_reg == ST_DATA && bit_done && bit_idx_reg != 3'd7) begin
            bit_idx_reg <= bit_idx_reg + 3'd1;
         end
      end
   end

   always_comb begin
      tx = 1'b1;
      case (state_reg)
         ST_START:  tx = 1'b0;
         ST_DATA:   tx = data_reg[bit_idx_reg];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: tx = ^data_reg;
`endif
         default:   tx = 1'b1;
      endcase
   end

   assign busy  = !idle;
   assign grant = grant_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized bench for uart_tx_arbiter with CLK_DIV=4; honours UART_TX_PARITY_EN.
module tb_uart_tx_arbiter;

   localparam int CLK_DIV = 4;
`ifdef UART_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif

   logic       sys_clk = 1'b0;
   logic       RSTn;
   logic       req0_valid, req1_valid;
   logic [7:0] req0_data, req1_data;
   logic       req0_ready, req1_ready;
   logic       tx, busy, grant;

   int checks = 0;
   int errors = 0;
   int prio_m = 0;
   logic [7:0] pend1;

   always #5 sys_clk = ~sys_clk;

   uart_tx_arbiter #(.CLK_DIV(CLK_DIV)) dut (
      .sys_clk    (sys_clk),
      .RSTn       (RSTn),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .tx         (tx),
      .busy       (busy),
      .grant      (grant)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected line level c cycles after the accepting edge: start, 8 data LSB first, [parity], stop.
   function automatic logic exp_bit(input logic [7:0] d, input int c);
      int idx;
      idx = c / CLK_DIV;
      if (idx == 0) return 1'b0;
      if (idx <= 8) return d[idx-1];
`ifdef UART_TX_PARITY_EN
      if (idx == 9) return ^d;
`endif
      return 1'b1;
   endfunction

   function automatic int pick(input logic v0, input logic v1);
      if (v0 && v1) return prio_m;
      return v1 ? 1 : 0;
   endfunction

   // Called at an IDLE negedge with inputs already driven; returns at the first IDLE negedge after the frame.
   // action: 0 keep valids, 1 drop winner valid, 2 also raise req1 mid-frame, 3 keep valid and corrupt data mid-frame.
   task automatic frame(input int who, input logic [7:0] d, input int action);
      #1;
      chk("entry_busy", busy, 0);
      chk("entry_tx", tx, 1);
      chk("ready0", req0_ready, who == 0);
      chk("ready1", req1_ready, who == 1);
      prio_m = 1 - who;
      for (int c = 0; c < FRAME_BITS * CLK_DIV; c++) begin
         @(negedge sys_clk);
         chk($sformatf("tx_c%0d", c), tx, exp_bit(d, c));
         chk("busy", busy, 1);
         chk("grant", grant, who);
         chk("ready_in_frame", {req0_ready, req1_ready}, 0);
         if (c == 0 && (action == 1 || action == 2)) begin
            if (who == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
         end
         if (action == 2 && c == 5) begin
            req1_valid = 1'b1;
            req1_data  = pend1;
         end
         if (action == 3 && c == 15) begin
            if (who == 0) req0_data = ~d; else req1_data = ~d;
         end
      end
      @(negedge sys_clk);
   endtask

   initial begin
      logic       v0, v1;
      logic [7:0] d0, d1;
      int         w;

      RSTn = 1'b0;
      req0_valid = 1'b1;
      req1_valid = 1'b0;
      req0_data  = 8'h00;
      req1_data  = 8'h00;
      repeat (3) @(negedge sys_clk);
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_grant", grant, 0);
      chk("rst_ready0", req0_ready, 0);
      req0_valid = 1'b0;
      RSTn = 1'b1;
      @(negedge sys_clk);
      chk("idle_tx", tx, 1);
      chk("idle_busy", busy, 0);
      chk("idle_ready", {req0_ready, req1_ready}, 0);
      prio_m = 0;

      // Both requesters contend continuously: frames must alternate 0, 1, 0.
      req0_valid = 1'b1; req0_data = 8'hA0;
      req1_valid = 1'b1; req1_data = 8'h0B;
      for (int i = 0; i < 3; i++) begin
         w = pick(req0_valid, req1_valid);
         chk("rr_order", w, (i % 2 == 0) ? 0 : 1);
         frame(w, (w == 1) ? 8'h0B : 8'hA0, 0);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;

      // Lone requester 0 with 0x55.
      req0_valid = 1'b1; req0_data = 8'h55;
      frame(pick(1'b1, 1'b0), 8'h55, 1);

      // req1 raised during a req0 frame is taken in the first IDLE cycle.
      d0 = 8'($urandom); pend1 = 8'($urandom);
      req0_valid = 1'b1; req0_data = d0;
      frame(0, d0, 2);
      frame(1, pend1, 1);

      // Data changed mid-frame must not alter the frame in flight.
      d0 = 8'($urandom);
      req0_valid = 1'b1; req0_data = d0;
      frame(0, d0, 3);
      req0_valid = 1'b0;

      // Reset during data bit 3 of a req1 0xFF frame, then the held byte is sent again.
      req1_valid = 1'b1; req1_data = 8'hFF;
      #1;
      chk("pre_rst_ready1", req1_ready, 1);
      for (int c = 0; c <= 4 + 3 * CLK_DIV + 1; c++) begin
         @(negedge sys_clk);
         chk("pre_rst_tx", tx, exp_bit(8'hFF, c));
      end
      chk("pre_rst_grant", grant, 1);
      RSTn = 1'b0;
      @(negedge sys_clk);
      chk("abort_tx", tx, 1);
      chk("abort_busy", busy, 0);
      chk("abort_grant", grant, 0);
      chk("abort_ready1", req1_ready, 0);
      RSTn = 1'b1;
      prio_m = 0;
      frame(1, 8'hFF, 1);

`ifdef UART_TX_PARITY_EN
      req0_valid = 1'b1; req0_data = 8'h07;
      frame(0, 8'h07, 1);
      req0_valid = 1'b1; req0_data = 8'h03;
      frame(0, 8'h03, 1);
`endif

      // Randomized traffic against the arbitration/framing model.
      for (int i = 0; i < 24; i++) begin
         v0 = 1'($urandom_range(0, 1));
         v1 = 1'($urandom_range(0, 1));
         d0 = 8'($urandom);
         d1 = 8'($urandom);
         req0_valid = v0; req0_data = d0;
         req1_valid = v1; req1_data = d1;
         if (!v0 && !v1) begin
            #1;
            chk("rand_idle_ready", {req0_ready, req1_ready}, 0);
            chk("rand_idle_tx", tx, 1);
            chk("rand_idle_busy", busy, 0);
            @(negedge sys_clk);
         end else begin
            w = pick(v0, v1);
            frame(w, (w == 1) ? d1 : d0, 1);
         end
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      #1;
      chk("final_busy", busy, 0);
      chk("final_tx", tx, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
